// File: rtl/poly_cbd_sampler.sv
// poly_cbd_sampler: centered-binomial sampler that fills a 256 x 12-bit polynomial RAM from a PRF byte stream
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   i_start / o_busy / o_done          start one polynomial, busy while sampling, one-cycle completion pulse
//   i_in_valid / o_in_ready / i_in_data  PRF byte stream (accepted on valid && ready)
//   i_ext_we / i_ext_addr / i_ext_din / o_ext_dout  host access to RAM port A while idle (1-cycle read latency)
//   i_eta3                             (only with KYBER_CBD_ETA3_EN) select eta=3, latched at start
// Build option: define KYBER_CBD_ETA3_EN to add eta=3 sampling (3 bytes -> 4 coefficients via S_EMIT).
module poly_cbd_sampler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
`ifdef KYBER_CBD_ETA3_EN
   input  logic        i_eta3,
`endif
   output logic        o_done,
   output logic        o_busy,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [7:0]  i_in_data,
   input  logic        i_ext_we,
   input  logic [7:0]  i_ext_addr,
   input  logic [11:0] i_ext_din,
   output logic [11:0] o_ext_dout
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_EMIT, S_DONE} state_t;
   state_t      r_state, w_state_nxt;
   logic [7:0]  r_idx;
   logic        r_done;
   logic [11:0] r_ram [0:255];
   logic [11:0] r_ext_dout;
   logic        w_we_a, w_we_b, w_step;
   logic [7:0]  w_addr_a, w_addr_b;
   logic [11:0] w_din_a, w_din_b;
`ifdef KYBER_CBD_ETA3_EN
   logic        r_eta3;
   logic [23:0] r_buf;
   logic [1:0]  r_bcnt;
   logic        r_phase;
`endif

   // a - b mod 3329 with a, b the popcounts of the two eta-bit halves of x
   function automatic logic [11:0] f_cbd(input logic [5:0] x, input logic eta3);
      logic [1:0] a, b;
      a = 2'(x[0]) + 2'(x[1]) + (eta3 ? 2'(x[2]) : 2'd0);
      b = eta3 ? 2'(x[3]) + 2'(x[4]) + 2'(x[5]) : 2'(x[2]) + 2'(x[3]);
      return (a >= b) ? {10'd0, a - b} : 12'd3329 - {10'd0, b - a};
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      o_in_ready  = 1'b0;
      w_we_a      = 1'b0;
      w_we_b      = 1'b0;
      w_step      = 1'b0;
      w_addr_a    = i_ext_addr;
      w_addr_b    = r_idx + 8'd1;
      w_din_a     = i_ext_din;
      w_din_b     = '0;
      case (r_state)
         S_IDLE: begin
            w_we_a = i_ext_we;
            if (i_start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            o_in_ready = 1'b1;
`ifdef KYBER_CBD_ETA3_EN
            if (r_eta3) begin
               if (i_in_valid && r_bcnt == 2'd2) w_state_nxt = S_EMIT;
            end else
`endif
            if (i_in_valid) begin
               w_we_a   = 1'b1;
               w_we_b   = 1'b1;
               w_step   = 1'b1;
               w_addr_a = r_idx;
               w_din_a  = f_cbd({2'b00, i_in_data[3:0]}, 1'b0);
               w_din_b  = f_cbd({2'b00, i_in_data[7:4]}, 1'b0);
               if (r_idx == 8'd254) w_state_nxt = S_DONE;
            end
         end
`ifdef KYBER_CBD_ETA3_EN
         S_EMIT: begin
            w_we_a   = 1'b1;
            w_we_b   = 1'b1;
            w_step   = 1'b1;
            w_addr_a = r_idx;
            w_din_a  = f_cbd(r_phase ? r_buf[17:12] : r_buf[5:0], 1'b1);
            w_din_b  = f_cbd(r_phase ? r_buf[23:18] : r_buf[11:6], 1'b1);
            if (r_phase) w_state_nxt = (r_idx == 8'd254) ? S_DONE : S_RUN;
         end
`endif
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_done <= 1'b0;
`ifdef KYBER_CBD_ETA3_EN
         r_eta3  <= 1'b0;
         r_buf   <= '0;
         r_bcnt  <= '0;
         r_phase <= 1'b0;
`endif
      end else begin
         r_done <= (r_state == S_DONE);
         if (r_state == S_IDLE && i_start) r_idx <= '0;
         else if (w_step)                  r_idx <= r_idx + 8'd2;
`ifdef KYBER_CBD_ETA3_EN
         if (r_state == S_IDLE && i_start) begin
            r_eta3  <= i_eta3;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
         end
         if (r_state == S_RUN && r_eta3 && i_in_valid) begin
            r_buf[{r_bcnt, 3'b000} +: 8] <= i_in_data;
            r_bcnt <= (r_bcnt == 2'd2) ? 2'd0 : r_bcnt + 2'd1;
         end
         if (r_state == S_EMIT) r_phase <= ~r_phase;
`endif
      end
   end

   // RAM is never reset so a partial result survives an aborted run
   always_ff @(posedge clk) begin
      if (w_we_a) r_ram[w_addr_a] <= w_din_a;
      if (w_we_b) r_ram[w_addr_b] <= w_din_b;
      r_ext_dout <= r_ram[i_ext_addr];
   end

   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;
   assign o_ext_dout = r_ext_dout;
endmodule

// File: tb/tb_poly_cbd_sampler.sv
// tb_poly_cbd_sampler: directed self-checking bench for poly_cbd_sampler (eta=3 cases need KYBER_CBD_ETA3_EN)
module tb_poly_cbd_sampler;
   logic        clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_eta3 = 1'b0;
   logic        i_in_valid = 1'b0, i_ext_we = 1'b0;
   logic [7:0]  i_in_data = '0, i_ext_addr = '0;
   logic [11:0] i_ext_din = '0;
   logic        o_done, o_busy, o_in_ready;
   logic [11:0] o_ext_dout;
   int          n_checks = 0, n_errors = 0;
   logic [7:0]  bq [0:191];
   int          exp_c [0:255];

   always #5 clk = ~clk;

   poly_cbd_sampler dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start),
`ifdef KYBER_CBD_ETA3_EN
      .i_eta3(i_eta3),
`endif
      .o_done(o_done), .o_busy(o_busy),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
      .i_ext_we(i_ext_we), .i_ext_addr(i_ext_addr), .i_ext_din(i_ext_din), .o_ext_dout(o_ext_dout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int tb_coef(input int x, input int eta);
      int a, b;
      a = $countones(x & ((1 << eta) - 1));
      b = $countones((x >> eta) & ((1 << eta) - 1));
      return (a >= b) ? a - b : 3329 - (b - a);
   endfunction

   task automatic set_bytes(input int mode, input int eta, input int n_exp);
      int x, g;
      for (int k = 0; k < 192; k++)
         case (mode)
            1:       bq[k] = (k == 0) ? 8'h03 : (k == 1) ? 8'hC0 : 8'h00;
            2:       bq[k] = 8'(k * 29 + 7);
            3:       bq[k] = 8'(k * 53 + 90);
            4:       bq[k] = 8'hFF;
            5:       bq[k] = (k == 0) ? 8'h07 : (k == 3) ? 8'h38 : 8'h00;
            default: bq[k] = 8'h00;
         endcase
      for (int i = 0; i < n_exp; i++) begin
         if (eta == 2) x = (i % 2 == 1) ? (int'(bq[i / 2]) >> 4) : (int'(bq[i / 2]) & 15);
         else begin
            g = i / 4;
            x = (((int'(bq[3 * g + 2]) << 16) | (int'(bq[3 * g + 1]) << 8) | int'(bq[3 * g])) >> (6 * (i % 4))) & 63;
         end
         exp_c[i] = tb_coef(x, eta);
      end
   endtask

   // cyc counts rising edges after the start edge; low counts in_ready=0 cycles while feeding
   task automatic run(input int n_bytes, input int n_feed, input bit eta3, input bit stall, input bit meddle,
                      output int cyc, output int low);
      int k;
      bit acc;
      k = 0; cyc = 0; low = 0;
      @(negedge clk);
      i_eta3  = eta3;
      i_start = 1'b1;
      @(negedge clk);
      if (!meddle) i_start = 1'b0;
      while (k < n_feed && cyc < 5000) begin
         i_in_valid = stall ? (cyc % 2 == 1) : 1'b1;
         i_in_data  = bq[k];
         i_ext_we   = meddle && k >= 10 && k < 20;
         i_ext_addr = 8'd5;
         i_ext_din  = 12'hFFF;
         if (!o_in_ready) low++;
         acc = i_in_valid && o_in_ready;
         @(negedge clk);
         cyc++;
         if (acc) k++;
      end
      i_in_valid = 1'b0;
      i_start    = 1'b0;
      i_ext_we   = 1'b0;
      check("bytes fed", k, n_feed);
      if (n_feed == n_bytes) begin
         while (!o_done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
         end
         check("done seen", o_done, 1);
         check("busy with done", o_busy, 0);
         @(negedge clk);
         check("done one cycle", o_done, 0);
      end
   endtask

   task automatic read_coef(input int a, output logic [11:0] v);
      @(negedge clk);
      i_ext_addr = 8'(a);
      @(negedge clk);
      v = o_ext_dout;
   endtask

   task automatic check_ram(input string tag, input int lo, input int hi);
      logic [11:0] v;
      for (int i = lo; i <= hi; i++) begin
         read_coef(i, v);
         check($sformatf("%s[%0d]", tag, i), v, exp_c[i]);
      end
   endtask

   task automatic check_029(input string tag);
      logic [11:0] v;
      read_coef(0, v); check({tag, " c0"}, v, 2);
      read_coef(1, v); check({tag, " c1"}, v, 0);
      read_coef(2, v); check({tag, " c2"}, v, 0);
      read_coef(3, v); check({tag, " c3"}, v, 3327);
   endtask

   initial begin
      int cyc, low;
      logic [11:0] v;
      repeat (2) @(negedge clk);
      check("rst busy", o_busy, 0);
      check("rst done", o_done, 0);
      check("rst ready", o_in_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-rst busy", o_busy, 0);
      check("post-rst done", o_done, 0);
      check("post-rst ready", o_in_ready, 0);
      i_in_valid = 1'b1;
      i_in_data  = 8'h55;
      repeat (3) @(negedge clk);
      check("idle ready", o_in_ready, 0);
      check("idle busy", o_busy, 0);
      i_in_valid = 1'b0;
      i_ext_we   = 1'b1;
      i_ext_addr = 8'd5;
      i_ext_din  = 12'h123;
      @(negedge clk);
      i_ext_we = 1'b0;
      @(negedge clk);
      check("host rw", o_ext_dout, 12'h123);

      set_bytes(0, 2, 256);
      run(128, 128, 1'b0, 1'b0, 1'b0, cyc, low);
      check("zero cycles", cyc, 129);
      check("zero ready low", low, 0);
      check_ram("zero", 0, 255);

      set_bytes(1, 2, 256);
      run(128, 128, 1'b0, 1'b0, 1'b0, cyc, low);
      check("vec cycles", cyc, 129);
      check_029("vec");
      check_ram("vec", 0, 255);

      set_bytes(0, 2, 256);
      run(128, 128, 1'b0, 1'b0, 1'b0, cyc, low);
      set_bytes(1, 2, 256);
      run(128, 128, 1'b0, 1'b1, 1'b0, cyc, low);
      check("stall cycles", cyc, 257);
      check("stall ready low", low, 0);
      check_029("stall");
      check_ram("stall", 0, 255);

      set_bytes(2, 2, 256);
      run(128, 128, 1'b0, 1'b0, 1'b1, cyc, low);
      check("meddle cycles", cyc, 129);
      read_coef(5, v);
      check("meddle c5", v, exp_c[5]);
      check_ram("patA", 0, 255);

      set_bytes(3, 2, 100);
      run(128, 50, 1'b0, 1'b0, 1'b0, cyc, low);
      check("mid busy before rst", o_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", o_busy, 0);
      check("abort done", o_done, 0);
      check("abort ready", o_in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check_ram("partial", 0, 255);

      set_bytes(4, 2, 256);
      run(128, 128, 1'b0, 1'b0, 1'b0, cyc, low);
      check("ff cycles", cyc, 129);
      check_ram("ff", 0, 255);

`ifdef KYBER_CBD_ETA3_EN
      set_bytes(5, 3, 256);
      run(192, 192, 1'b1, 1'b0, 1'b0, cyc, low);
      check("eta3 cycles", cyc, 321);
      check("eta3 ready low", low, 126);
      read_coef(0, v); check("eta3 c0", v, 3);
      read_coef(1, v); check("eta3 c1", v, 0);
      read_coef(3, v); check("eta3 c3", v, 0);
      read_coef(4, v); check("eta3 c4", v, 3326);
      check_ram("eta3", 0, 255);
      set_bytes(1, 2, 256);
      run(128, 128, 1'b0, 1'b0, 1'b0, cyc, low);
      check("eta2 after eta3 cycles", cyc, 129);
      check_029("eta2 after eta3");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/poly_cbd_sampler.md
POLY_CBD_SAMPLER -- requirements
Module: poly_cbd_sampler

Interface
REQ-001 SHALL provide: clk  input  1  clock; all sequential logic on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: start  input  1  begin sampling one polynomial; ignored while busy.
REQ-004 SHALL provide: done  output  1  registered one-cycle completion pulse.
REQ-005 SHALL provide: busy  output  1  high whenever state != S_IDLE.
REQ-006 SHALL provide: in_valid  input  1 / in_ready  output  1 / in_data  input  8  PRF byte stream; a byte is accepted on a rising edge with in_valid && in_ready.
REQ-007 SHALL provide: ext_we  input  1, ext_addr  input  8, ext_din  input  12, ext_dout  output  12  host access to the internal poly_ram port A.

Function
REQ-008 SHALL hold one 256 x 12-bit poly_ram; coefficient i at address i.
REQ-009 SHALL implement states S_IDLE, S_RUN, S_EMIT, S_DONE.
REQ-010 S_IDLE: in_ready=0; ext port drives RAM port A; ext_dout = sync read, 1-cycle latency; start -> S_RUN, coefficient index cleared.
REQ-011 S_RUN/S_EMIT/S_DONE: ext_we ignored, RAM not host-written; ext_dout undefined.
REQ-012 Coefficient from 2*eta bits x: a = popcount(x[eta-1:0]), b = popcount(x[2eta-1:eta]); value = a-b if a>=b, else 3329-(b-a); always in [0,3328].
REQ-013 eta=2, S_RUN: in_ready=1; each accepted byte k (0..127) writes coeff 2k from in_data[3:0] (port A) and 2k+1 from in_data[7:4] (port B) at the acceptance edge.
REQ-014 eta=2: acceptance of byte 127 -> S_DONE.
REQ-015 in_valid=0 in S_RUN stalls indefinitely; no writes, no index change.
REQ-016 S_DONE lasts one cycle; its exit edge sets done=1 and returns to S_IDLE; done=0 all other cycles.
REQ-017 start asserted while busy SHALL have no effect; start in the S_DONE->S_IDLE cycle is not seen until S_IDLE.
REQ-018 Bytes offered in S_IDLE are never consumed.

Reset
REQ-019 rst_n low SHALL force state=S_IDLE, done=0, coefficient index=0, byte buffer=0, eta latch=0, immediately and asynchronously.
REQ-020 Reset mid-operation SHALL abort; RAM contents are not cleared (partial result remains, host-readable).
REQ-021 After reset release: busy=0, in_ready=0, done=0.

Configuration
REQ-022 Macro KYBER_CBD_ETA3_EN SHALL gate eta=3 support.
REQ-023 Undefined: eta fixed at 2; no eta3 port; S_EMIT unreachable; 24-bit buffer absent.
REQ-024 Defined: add input eta3 (1 bit), latched at start; eta3=0 behaves exactly as REQ-013/014.
REQ-025 Defined, eta3=1: S_RUN in_ready=1; bytes stored into 24-bit buffer, byte j of group at bits [8j+7:8j]; third byte of group -> S_EMIT.
REQ-026 S_EMIT (eta3=1): in_ready=0 for 2 cycles; cycle 0 writes coeffs 4g, 4g+1 from bits [5:0],[11:6]; cycle 1 writes 4g+2, 4g+3 from [17:12],[23:18]; then S_RUN, or S_DONE after group 63 (192 bytes total).
REQ-027 eta3=1 minimum start-to-done: 1 + 192 + 128 + 1 cycles at full in_valid.

Verification
REQ-028 eta=2, 128 bytes 0x00 back-to-back -> all 256 coeffs read 0; done one cycle, busy drops with it; 130 cycles start-edge to done.
REQ-029 eta=2, byte0=0x03, byte1=0xC0, rest 0x00 -> coeff0=2, coeff1=0, coeff2=0, coeff3=3327; 0xFF bytes -> coeffs 0.
REQ-030 eta=2, in_valid toggled 1/0 each cycle -> same RAM contents as REQ-029; in_ready stays 1 in S_RUN; done 128 cycles later than unstalled.
REQ-031 rst_n pulsed low after 50 bytes -> busy=0, done=0 immediately; coeffs 0..99 hold written values; fresh start resamples from coeff 0.
REQ-032 KYBER_CBD_ETA3_EN, eta3=1, bytes 0x07,0x00,0x00 then 0x38,0x00,0x00 -> coeff0=3, coeff1..3=0, coeff4=3326; in_ready low 2 cycles after each third byte.
REQ-033 start held high during S_RUN and ext_we=1 with ext_addr=5 mid-run -> no restart, coeff5 holds sampled value.
